// File: rtl/aes_encoder.sv
// AES-128/192/256 encryption core, one round per pipeline stage.
// Each stage carries its own key-schedule window, so the key may change every cycle.
module aes_encoder #(
    parameter int KEY_SIZE  = 128,
    parameter int KEY_BYTES = KEY_SIZE / 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [127:0]        plain,
    input  logic [KEY_SIZE-1:0] key,
    output logic [127:0]        cipher,
    output logic                valid
);
    localparam int NK         = KEY_BYTES / 4;
    localparam int NUM_ROUNDS = NK + 6;

    // Scratch buffer: the carried Nk-word window plus up to four freshly expanded words.
    typedef logic [NK+3:0][31:0] ext_t;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        case (j)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Index of the newest schedule word held once round key rnd is available.
    function automatic int last_word(input int rnd);
        return (4 * rnd + 3 > NK - 1) ? 4 * rnd + 3 : NK - 1;
    endfunction

    // Expand the window entering round rnd until it reaches the last word of round key rnd.
    function automatic ext_t extend(input logic [KEY_SIZE-1:0] win, input int rnd);
        ext_t        w;
        int          prev;
        int          ngen;
        int          i;
        logic [31:0] t;
        w    = '0;
        prev = last_word(rnd - 1);
        ngen = last_word(rnd) - prev;
        for (int p = 0; p < NK; p++) w[p] = win[KEY_SIZE-1-32*p -: 32];
        for (int n = 0; n < 4; n++) begin
            if (n < ngen) begin
                i = prev + 1 + n;
                t = w[NK-1+n];
                if (i % NK == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h0};
                else if (NK > 6 && i % NK == 4)
                    t = sub_word(t);
                w[NK+n] = w[n] ^ t;
            end
        end
        return w;
    endfunction

    function automatic logic [KEY_SIZE-1:0] next_window(input logic [KEY_SIZE-1:0] win, input int rnd);
        ext_t                w    = extend(win, rnd);
        int                  ngen = last_word(rnd) - last_word(rnd - 1);
        logic [KEY_SIZE-1:0] o    = '0;
        for (int p = 0; p < NK; p++) o[KEY_SIZE-1-32*p -: 32] = w[ngen+p];
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [KEY_SIZE-1:0] win, input int rnd);
        ext_t         w     = extend(win, rnd);
        int           first = 4 * rnd - (last_word(rnd - 1) - NK + 1);
        logic [127:0] o     = '0;
        for (int q = 0; q < 4; q++) o[127-32*q -: 32] = w[first+q];
        return o;
    endfunction

    // SubBytes followed by ShiftRows; byte k of the state is row k%4, column k/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    for (genvar g = 0; g < NUM_ROUNDS; g++) begin : g_round
        logic [127:0]        w_in;
        logic [KEY_SIZE-1:0] w_win;
        logic                w_vld;
        logic [127:0]        w_mixed;
        logic [127:0]        r_state;
        logic                r_vld;

        if (g == 0) begin : g_first
            // Initial AddRoundKey uses the first four key words directly.
            assign w_in  = plain ^ key[KEY_SIZE-1 -: 128];
            assign w_win = key;
            assign w_vld = 1'b1;
        end else begin : g_next
            assign w_in  = g_round[g-1].r_state;
            assign w_win = g_round[g-1].g_key.r_win;
            assign w_vld = g_round[g-1].r_vld;
        end

        if (g == NUM_ROUNDS - 1) begin : g_last
            assign w_mixed = sub_shift(w_in);
        end else begin : g_mid
            assign w_mixed = mix_columns(sub_shift(w_in));
        end

        // Round g+1 result and its valid bit, cleared together on reset
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state <= '0;
                r_vld   <= 1'b0;
            end else begin
                r_state <= w_mixed ^ round_key(w_win, g + 1);
                r_vld   <= w_vld;
            end
        end

        if (g < NUM_ROUNDS - 1) begin : g_key
            logic [KEY_SIZE-1:0] r_win;
            // Key-schedule window handed to the next round alongside its data
            always_ff @(posedge clock) begin
                if (reset) r_win <= '0;
                else       r_win <= next_window(w_win, g + 1);
            end
        end
    end

    assign cipher = g_round[NUM_ROUNDS-1].r_state;
    assign valid  = g_round[NUM_ROUNDS-1].r_vld;
endmodule

// File: tb/tb_aes_encoder.sv
// Bench for aes_encoder: three instances (128/192/256-bit keys) against a byte-level AES model.
module tb_aes_encoder;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] plain = '0;
    logic [127:0] key128 = '0;
    logic [191:0] key192 = '0;
    logic [255:0] key256 = '0;
    logic [127:0] ct128, ct192, ct256;
    logic         vld128, vld192, vld256;

    int n_total = 0;
    int n_bad   = 0;
    int edge_n  = 0;

    logic [7:0]   sb    [256];
    logic         rst_h [2048];
    logic [127:0] exp_a [2048];
    logic [127:0] exp_b [2048];
    logic [127:0] exp_c [2048];

    localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_encoder #(.KEY_SIZE(128)) u_dut128 (.clock(clock), .reset(reset), .plain(plain),
                                            .key(key128), .cipher(ct128), .valid(vld128));
    aes_encoder #(.KEY_SIZE(192)) u_dut192 (.clock(clock), .reset(reset), .plain(plain),
                                            .key(key192), .cipher(ct192), .valid(vld192));
    aes_encoder #(.KEY_SIZE(256)) u_dut256 (.clock(clock), .reset(reset), .plain(plain),
                                            .key(key256), .cipher(ct256), .valid(vld256));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Straight FIPS-197 cipher with a fully expanded key schedule; key is left-aligned.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int nk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [60];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] o;
        int           nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                if (rnd < nr) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Output after edge n holds the block sampled at edge n-nr+1, valid if no reset since then.
    function automatic logic window_ok(input int nr);
        for (int j = edge_n - nr + 1; j <= edge_n; j++)
            if (j < 1 || rst_h[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic score();
        logic ok;
        ok = window_ok(10);
        chk("vld128", {127'b0, vld128}, {127'b0, ok});
        if (ok) chk("ct128", ct128, exp_a[edge_n-9]);
        ok = window_ok(12);
        chk("vld192", {127'b0, vld192}, {127'b0, ok});
        if (ok) chk("ct192", ct192, exp_b[edge_n-11]);
        ok = window_ok(14);
        chk("vld256", {127'b0, vld256}, {127'b0, ok});
        if (ok) chk("ct256", ct256, exp_c[edge_n-13]);
    endtask

    task automatic step(input logic r, input logic [127:0] p, input logic [127:0] ka,
                        input logic [191:0] kb, input logic [255:0] kc);
        int e;
        reset  = r;
        plain  = p;
        key128 = ka;
        key192 = kb;
        key256 = kc;
        e = edge_n + 1;
        rst_h[e] = r;
        exp_a[e] = aes_ref(p, {ka, 128'h0}, 4);
        exp_b[e] = aes_ref(p, {kb, 64'h0}, 6);
        exp_c[e] = aes_ref(p, kc, 8);
        @(posedge clock);
        #1;
        edge_n = e;
        score();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ct128"}, ct128, 128'h0);
        chk({tag, "_ct192"}, ct192, 128'h0);
        chk({tag, "_ct256"}, ct256, 128'h0);
    endtask

    initial begin
        logic [255:0] rk;
        logic [127:0] one;
        build_sbox();

        for (int i = 0; i < 3; i++) begin
            rk = rand256();
            step(1'b1, rk[255:128], rk[127:0], rk[191:0], rk);
        end
        chk_cleared("rst");

        for (int i = 1; i <= 16; i++) begin
            step(1'b0, V1P, V1K, K192, K256);
            if (i == 9)  chk("kat128_early", {127'b0, vld128}, 128'h0);
            if (i == 10) begin
                chk("kat128_vld", {127'b0, vld128}, 128'h1);
                chk("kat128", ct128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
            end
            if (i == 11) chk("kat192_early", {127'b0, vld192}, 128'h0);
            if (i == 12) begin
                chk("kat192_vld", {127'b0, vld192}, 128'h1);
                chk("kat192", ct192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
            end
            if (i == 13) chk("kat256_early", {127'b0, vld256}, 128'h0);
            if (i == 14) begin
                chk("kat256_vld", {127'b0, vld256}, 128'h1);
                chk("kat256", ct256, 128'h8ea2b7ca516745bfeafc49904b496089);
            end
        end

        for (int b = 0; b < 20; b++) begin
            rk = rand256();
            if (b % 2 == 0) step(1'b0, V2P, V2K, rk[191:0], rk);
            else            step(1'b0, V1P, V1K, rk[191:0], rk);
            if (b == 9)  chk("kat128_v2", ct128, 128'h3925841d02dc09fbdc118597196a0b32);
            if (b == 10) chk("kat128_v1", ct128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        end

        one = 128'h1;
        for (int b = 0; b < 128; b++) begin
            rk = rand256();
            step(1'b0, V2P ^ (one << b), V2K, rk[191:0], rk);
        end
        for (int b = 0; b < 128; b++) begin
            rk = rand256();
            step(1'b0, V2P ^ (one << b), ~V2K, rk[191:0], ~rk);
        end

        for (int i = 0; i < 40; i++) begin
            rk = rand256();
            step(1'b0, {$urandom, $urandom, $urandom, $urandom}, rk[255:128], rk[191:0], rk);
        end

        rk = rand256();
        step(1'b1, rk[127:0], rk[255:128], rk[191:0], rk);
        chk_cleared("midrst");

        for (int i = 0; i < 30; i++) begin
            rk = rand256();
            step(1'b0, {$urandom, $urandom, $urandom, $urandom}, rk[255:128], rk[191:0], rk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
